// File: rtl/usb_tx_gen.sv
// USB packet transmitter: SYNC, PID, optional payload and CRC16, then EOP, NRZI-encoded
// with bit stuffing onto a registered D+/D- pair.
module usb_tx_gen #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64,
    parameter int CRC_EN       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] tx_packet_size,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    MAX_SIZE = 7'(MAX_BYTES);
    localparam logic          CRC_ON   = (CRC_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_EOP  = 3'd5
    } state_t;

    // Reflected CRC16 (0x8005 -> 0xA001), one payload bit per call, LSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        crc16_step = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    endfunction

    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        case (code)
            3'd1:    pid_byte = 8'hC3;
            3'd2:    pid_byte = 8'h4B;
            3'd3:    pid_byte = 8'hD2;
            3'd4:    pid_byte = 8'h5A;
            3'd5:    pid_byte = 8'h1E;
            default: pid_byte = 8'h00;
        endcase
    endfunction

    state_t        state_r;
    logic [3:0]    idx_r;
    logic [CW-1:0] bit_cnt_r;
    logic [2:0]    ones_r;
    logic          level_r;
    logic [15:0]   crc_r;
    logic [7:0]    pid_r;
    logic [7:0]    byte_r;
    logic [6:0]    bytes_left_r;
    logic          is_data_r;
    logic          dplus_r;
    logic          dminus_r;
    logic          get_r;
    logic          active_r;
    logic          error_r;

    logic          req_data_s;
    logic          req_legal_s;
    logic          req_reject_s;
    logic          stuff_now_s;
    state_t        tail_s;
    state_t        nxt_state_s;
    logic [3:0]    nxt_idx_s;
    logic [7:0]    byte_src_s;
    logic          nxt_bit_s;
    logic          nxt_level_s;
    logic          nxt_get_s;

    // Request decode, only acted on while idle.
    always_comb begin
        req_data_s   = (tx_packet == 3'd1) || (tx_packet == 3'd2);
        req_legal_s  = (tx_packet != 3'd0) && (tx_packet <= 3'd5);
        req_reject_s = (tx_packet >= 3'd6) || (req_data_s && (tx_packet_size > MAX_SIZE));
    end

    // Next field position after the bit currently on the line.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r + 4'd1;
        if (is_data_r && CRC_ON) begin
            tail_s = ST_CRC;
        end else begin
            tail_s = ST_EOP;
        end
        case (state_r)
            ST_SYNC: begin
                if (idx_r == 4'd7) begin
                    nxt_state_s = ST_PID;
                    nxt_idx_s   = 4'd0;
                end else begin
                    nxt_state_s = ST_SYNC;
                end
            end
            ST_PID: begin
                if (idx_r == 4'd7) begin
                    nxt_idx_s = 4'd0;
                    if (is_data_r && (bytes_left_r != 7'd0)) begin
                        nxt_state_s = ST_DATA;
                    end else begin
                        nxt_state_s = tail_s;
                    end
                end else begin
                    nxt_state_s = ST_PID;
                end
            end
            ST_DATA: begin
                if (idx_r == 4'd7) begin
                    nxt_idx_s = 4'd0;
                    if (bytes_left_r != 7'd0) begin
                        nxt_state_s = ST_DATA;
                    end else begin
                        nxt_state_s = tail_s;
                    end
                end else begin
                    nxt_state_s = ST_DATA;
                end
            end
            ST_CRC: begin
                if (idx_r == 4'd15) begin
                    nxt_state_s = ST_EOP;
                    nxt_idx_s   = 4'd0;
                end else begin
                    nxt_state_s = ST_CRC;
                end
            end
            ST_EOP: begin
                if (idx_r == 4'd2) begin
                    nxt_state_s = ST_IDLE;
                    nxt_idx_s   = 4'd0;
                end else begin
                    nxt_state_s = ST_EOP;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_idx_s   = 4'd0;
            end
        endcase
    end

    // Value of the next line bit; a freshly requested byte is used straight off the input.
    always_comb begin
        if (get_r) begin
            byte_src_s = tx_packet_data;
        end else begin
            byte_src_s = byte_r;
        end
        case (nxt_state_s)
            ST_SYNC: nxt_bit_s = (nxt_idx_s == 4'd7);
            ST_PID:  nxt_bit_s = pid_r[nxt_idx_s[2:0]];
            ST_DATA: nxt_bit_s = byte_src_s[nxt_idx_s[2:0]];
            ST_CRC:  nxt_bit_s = ~crc_r[nxt_idx_s];
            default: nxt_bit_s = 1'b1;
        endcase
        nxt_level_s = nxt_bit_s ? level_r : ~level_r;
        nxt_get_s   = (nxt_idx_s == 4'd7) && (bytes_left_r != 7'd0) &&
                      (((nxt_state_s == ST_PID) && is_data_r) || (nxt_state_s == ST_DATA));
        stuff_now_s = (ones_r == 3'd6) &&
                      ((state_r == ST_SYNC) || (state_r == ST_PID) ||
                       (state_r == ST_DATA) || (state_r == ST_CRC));
    end

    // Packet FSM, bit timing, NRZI/stuffing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 4'd0;
            bit_cnt_r    <= '0;
            ones_r       <= 3'd0;
            level_r      <= 1'b1;
            crc_r        <= 16'hFFFF;
            pid_r        <= 8'h00;
            byte_r       <= 8'h00;
            bytes_left_r <= 7'd0;
            is_data_r    <= 1'b0;
            dplus_r      <= 1'b1;
            dminus_r     <= 1'b0;
            get_r        <= 1'b0;
            active_r     <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            get_r   <= 1'b0;
            error_r <= 1'b0;
            if (get_r) begin
                byte_r <= tx_packet_data;
            end
            if (state_r == ST_IDLE) begin
                if (req_reject_s) begin
                    error_r <= 1'b1;
                end else if (req_legal_s) begin
                    // First SYNC bit is a 0, so the line toggles away from J immediately.
                    state_r      <= ST_SYNC;
                    idx_r        <= 4'd0;
                    bit_cnt_r    <= '0;
                    ones_r       <= 3'd0;
                    level_r      <= 1'b0;
                    dplus_r      <= 1'b0;
                    dminus_r     <= 1'b1;
                    crc_r        <= 16'hFFFF;
                    pid_r        <= pid_byte(tx_packet);
                    bytes_left_r <= req_data_s ? tx_packet_size : 7'd0;
                    is_data_r    <= req_data_s;
                    active_r     <= 1'b1;
                end
            end else if (bit_cnt_r != LAST_CLK) begin
                bit_cnt_r <= bit_cnt_r + 1'b1;
            end else begin
                bit_cnt_r <= '0;
                if (stuff_now_s) begin
                    ones_r   <= 3'd0;
                    level_r  <= ~level_r;
                    dplus_r  <= ~level_r;
                    dminus_r <= level_r;
                end else begin
                    state_r <= nxt_state_s;
                    idx_r   <= nxt_idx_s;
                    case (nxt_state_s)
                        ST_IDLE: begin
                            active_r <= 1'b0;
                            level_r  <= 1'b1;
                            dplus_r  <= 1'b1;
                            dminus_r <= 1'b0;
                        end
                        ST_EOP: begin
                            level_r  <= 1'b1;
                            dplus_r  <= (nxt_idx_s == 4'd2);
                            dminus_r <= 1'b0;
                        end
                        default: begin
                            level_r  <= nxt_level_s;
                            dplus_r  <= nxt_level_s;
                            dminus_r <= ~nxt_level_s;
                            ones_r   <= nxt_bit_s ? (ones_r + 3'd1) : 3'd0;
                            get_r    <= nxt_get_s;
                            if (nxt_state_s == ST_DATA) begin
                                crc_r <= crc16_step(crc_r, nxt_bit_s);
                                if (nxt_idx_s == 4'd0) begin
                                    bytes_left_r <= bytes_left_r - 7'd1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign dplus_out          = dplus_r;
    assign dminus_out         = dminus_r;
    assign get_tx_packet_data = get_r;
    assign tx_transfer_active = active_r;
    assign tx_error           = error_r;

endmodule

// File: tb/tb_usb_tx_gen.sv
// Bench for usb_tx_gen: three configurations checked cycle by cycle against a line-symbol model.
module tb_usb_tx_gen;
    logic       tb_clk = 1'b0;
    logic       rst;
    logic [2:0] tx_packet;
    logic [6:0] tx_packet_size;
    logic [7:0] tx_packet_data;
    int         sel;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] pkt_a, pkt_b, pkt_c;
    logic       dp_a, dm_a, get_a, act_a, err_a;
    logic       dp_b, dm_b, get_b, act_b, err_b;
    logic       dp_c, dm_c, get_c, act_c, err_c;
    logic       dp, dm, get, act, err;

    logic [7:0] payload [0:127];
    bit         raw_q [$];
    bit         rtag_q [$];
    logic [1:0] sym_q [$];
    bit         tag_q [$];

    always #5 tb_clk = ~tb_clk;

    assign pkt_a = (sel == 0) ? tx_packet : 3'd0;
    assign pkt_b = (sel == 1) ? tx_packet : 3'd0;
    assign pkt_c = (sel == 2) ? tx_packet : 3'd0;

    usb_tx_gen #(.CLKS_PER_BIT(1), .MAX_BYTES(64), .CRC_EN(1)) u_a (
        .clk(tb_clk), .rst(rst), .tx_packet(pkt_a), .tx_packet_size(tx_packet_size),
        .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_a), .dplus_out(dp_a),
        .dminus_out(dm_a), .tx_transfer_active(act_a), .tx_error(err_a));
    usb_tx_gen #(.CLKS_PER_BIT(8), .MAX_BYTES(64), .CRC_EN(1)) u_b (
        .clk(tb_clk), .rst(rst), .tx_packet(pkt_b), .tx_packet_size(tx_packet_size),
        .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_b), .dplus_out(dp_b),
        .dminus_out(dm_b), .tx_transfer_active(act_b), .tx_error(err_b));
    usb_tx_gen #(.CLKS_PER_BIT(2), .MAX_BYTES(4), .CRC_EN(0)) u_c (
        .clk(tb_clk), .rst(rst), .tx_packet(pkt_c), .tx_packet_size(tx_packet_size),
        .tx_packet_data(tx_packet_data), .get_tx_packet_data(get_c), .dplus_out(dp_c),
        .dminus_out(dm_c), .tx_transfer_active(act_c), .tx_error(err_c));

    always_comb begin
        case (sel)
            0:       {dp, dm, get, act, err} = {dp_a, dm_a, get_a, act_a, err_a};
            1:       {dp, dm, get, act, err} = {dp_b, dm_b, get_b, act_b, err_b};
            default: {dp, dm, get, act, err} = {dp_c, dm_c, get_c, act_c, err_c};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-16/USB over payload[0..n-1], byte at a time, result complemented.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, payload[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void push_byte(input logic [7:0] v, input bit tag_last);
        for (int i = 0; i < 8; i++) begin
            raw_q.push_back(v[i]);
            rtag_q.push_back((i == 7) && tag_last);
        end
    endfunction

    // Build the expected symbol stream, present the request and check every cycle of the packet.
    task automatic send(input int s, input int code, input int size, input int abort_at);
        int          cpb, total, gi, pulses, ones;
        bit          crcen, is_data, exp_get;
        logic        level;
        logic [7:0]  pid;
        logic [15:0] crc;
        cpb   = (s == 0) ? 1 : ((s == 1) ? 8 : 2);
        crcen = (s != 2);
        sel   = s;
        case (code)
            1: pid = 8'hC3;
            2: pid = 8'h4B;
            3: pid = 8'hD2;
            4: pid = 8'h5A;
            default: pid = 8'h1E;
        endcase
        is_data = (code == 1) || (code == 2);
        raw_q.delete(); rtag_q.delete(); sym_q.delete(); tag_q.delete();
        push_byte(8'h80, 1'b0);
        push_byte(pid, is_data && (size > 0));
        if (is_data) begin
            for (int j = 0; j < size; j++) push_byte(payload[j], j < size - 1);
            if (crcen) begin
                crc = crc_model(size);
                push_byte(crc[7:0], 1'b0);
                push_byte(crc[15:8], 1'b0);
            end
        end
        level = 1'b1;
        ones  = 0;
        foreach (raw_q[i]) begin
            if (!raw_q[i]) level = ~level;
            sym_q.push_back({level, ~level});
            tag_q.push_back(rtag_q[i]);
            ones = raw_q[i] ? ones + 1 : 0;
            if (ones == 6) begin
                level = ~level;
                sym_q.push_back({level, ~level});
                tag_q.push_back(1'b0);
                ones = 0;
            end
        end
        sym_q.push_back(2'b00); sym_q.push_back(2'b00); sym_q.push_back(2'b10);
        repeat (3) tag_q.push_back(1'b0);
        total  = sym_q.size() * cpb;
        gi     = 0;
        pulses = 0;
        tx_packet      = 3'(code);
        tx_packet_size = 7'(size);
        @(posedge tb_clk);
        for (int k = 0; k < total; k++) begin
            @(negedge tb_clk);
            if (k == abort_at) return;
            exp_get = ((k % cpb) == 0) && tag_q[k / cpb];
            chk($sformatf("line s%0d c%0d k%0d", s, code, k), {dp, dm}, sym_q[k / cpb]);
            chk($sformatf("active s%0d k%0d", s, k), act, 1);
            chk($sformatf("get s%0d k%0d", s, k), get, exp_get);
            chk($sformatf("err s%0d k%0d", s, k), err, 0);
            if (get) begin
                pulses++;
                tx_packet_data = (gi < size) ? payload[gi] : 8'($urandom);
                gi++;
            end else begin
                tx_packet_data = 8'($urandom);
            end
            if (k < total - 1) begin
                tx_packet      = 3'($urandom);
                tx_packet_size = 7'($urandom);
            end else begin
                tx_packet = 3'd0;
            end
        end
        @(negedge tb_clk);
        chk($sformatf("idle s%0d", s), {dp, dm, act, get}, 4'b1000);
        chk($sformatf("pulses s%0d", s), pulses, is_data ? size : 0);
    endtask

    task automatic reject(input int s, input int code, input int size);
        sel            = s;
        tx_packet      = 3'(code);
        tx_packet_size = 7'(size);
        @(posedge tb_clk);
        @(negedge tb_clk);
        chk($sformatf("rej s%0d c%0d", s, code), {dp, dm, act, get, err}, 5'b10001);
        tx_packet = 3'd0;
        @(negedge tb_clk);
        chk($sformatf("rej_after s%0d", s), {dp, dm, act, get, err}, 5'b10000);
    endtask

    initial begin
        int s, code, size, mx;
        rst            = 1'b1;
        tx_packet      = 3'd0;
        tx_packet_size = 7'd0;
        tx_packet_data = 8'h00;
        sel            = 0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        chk("rst_a", {dp_a, dm_a, act_a, get_a, err_a}, 5'b10000);
        chk("rst_b", {dp_b, dm_b, act_b, get_b, err_b}, 5'b10000);
        chk("rst_c", {dp_c, dm_c, act_c, get_c, err_c}, 5'b10000);
        rst = 1'b0;
        @(negedge tb_clk);

        send(0, 3, 0, -1);
        send(1, 4, 0, -1);
        send(1, 5, 0, -1);
        payload[0] = 8'hFF;
        send(2, 1, 1, -1);
        payload[0] = 8'h00; payload[1] = 8'h01;
        send(0, 2, 2, -1);
        send(0, 1, 0, -1);
        for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
        send(2, 2, 4, -1);

        reject(0, 1, 65);
        reject(2, 1, 5);
        reject(0, 7, 0);
        reject(1, 6, 3);

        for (int i = 0; i < 3; i++) payload[i] = 8'($urandom);
        send(1, 1, 3, 163);
        rst       = 1'b1;
        tx_packet = 3'd0;
        @(posedge tb_clk);
        @(negedge tb_clk);
        chk("mid_rst", {dp, dm, act, get, err}, 5'b10000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk);
            chk($sformatf("post_rst %0d", i), {dp, dm, act, get, err}, 5'b10000);
        end
        send(1, 3, 0, -1);

        for (int n = 0; n < 10; n++) begin
            s    = $urandom_range(0, 2);
            code = $urandom_range(1, 5);
            mx   = (s == 2) ? 4 : ((s == 1) ? 6 : 40);
            size = $urandom_range(0, mx);
            for (int i = 0; i < size; i++)
                payload[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            send(s, code, size, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_tx_gen.md
USB_TX_GEN -- requirements
Module: usb_tx_gen

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit time (legal range >=1).
REQ-002 SHALL have parameter MAX_BYTES, default 64, meaning the largest legal data payload in bytes (legal range 1..127).
REQ-003 SHALL have parameter CRC_EN, default 1, meaning CRC16 is appended to data packets when 1 and omitted when 0.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port tx_packet, input, 3 bits: packet request. Encoding: 0 IDLE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 6 and 7 are illegal.
REQ-007 SHALL have port tx_packet_size, input, 7 bits: payload byte count, sampled at packet start.
REQ-008 SHALL have port tx_packet_data, input, 8 bits: payload byte, sampled on the edge that ends a get_tx_packet_data pulse.
REQ-009 SHALL have port get_tx_packet_data, output, 1 bit: one-cycle payload byte request.
REQ-010 SHALL have ports dplus_out and dminus_out, outputs, 1 bit each: the USB line pair.
REQ-011 SHALL have port tx_transfer_active, output, 1 bit: high from packet start through the end of EOP.
REQ-012 SHALL have port tx_error, output, 1 bit: one-cycle pulse on a rejected request.

Function
REQ-013 SHALL drive idle J (dplus=1, dminus=0) whenever no packet is in progress.
REQ-014 SHALL sample tx_packet in IDLE state only, and SHALL start a packet on the edge that sees a legal nonzero code.
- Payload size and CRC_EN are checked at this edge.
- tx_transfer_active rises on the same edge.
- The first SYNC bit is driven in the following cycle.
REQ-015 SHALL implement FSM states IDLE -> SYNC -> PID -> DATA -> CRC -> EOP -> IDLE.
- DATA and CRC apply only to DATA0/DATA1.
- DATA is skipped when size=0.
- CRC is skipped when CRC_EN=0.
REQ-016 SHALL hold each line bit for exactly CLKS_PER_BIT cycles, with bit boundaries aligned to the internal bit-period counter.
REQ-017 SHALL send every byte LSB first, with these values:
- SYNC 0x80.
- PID: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
REQ-018 SHALL NRZI-encode the stream: a 0 bit toggles the line state, a 1 bit holds it; encoding starts from J.
REQ-019 SHALL bit-stuff: after six consecutive 1s, insert one 0 bit, NRZI-encoded as a toggle.
- The ones count starts at SYNC and spans byte and field boundaries.
- The count clears on any 0, including a stuffed 0.
- EOP is never stuffed.
REQ-020 SHALL pulse get_tx_packet_data once per payload byte, exactly size pulses per packet.
- Each pulse occurs in the first clk of the final bit period of the preceding PID or data byte.
- The next byte is latched on the same edge the pulse ends.
- A stall from stuffing does not duplicate the pulse.
REQ-021 SHALL compute CRC16 over the payload bytes only:
- polynomial 0x8005, bits processed LSB first;
- initial value 0xFFFF, output complemented;
- sent LSB first.
Empty payload gives CRC 0x0000.
REQ-022 SHALL generate EOP after the last bit, then return to IDLE:
- two bit periods of SE0 (dplus=0, dminus=0);
- one bit period of J.
tx_transfer_active falls on the edge that enters IDLE.
REQ-023 SHALL reject, with one tx_error pulse and no line activity (FSM stays IDLE):
- a data request with size > MAX_BYTES;
- an illegal tx_packet code.
REQ-024 SHALL ignore tx_packet and tx_packet_size changes while a packet is in progress.
REQ-025 SHALL accept a new request on the first cycle back in IDLE, giving back-to-back packets with no gap beyond EOP.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, force the following regardless of state, including mid-packet:
- FSM IDLE;
- dplus_out=1, dminus_out=0;
- get_tx_packet_data=0, tx_transfer_active=0, tx_error=0;
- NRZI state J, stuff count 0, CRC 0xFFFF, bit counter 0.
REQ-027 SHALL not emit an EOP or partial byte after reset releases; lines remain J until a new request.

Verification
REQ-028 ACK, CLKS_PER_BIT=1 -> dplus sequence per bit 0,1,0,1,0,1,0,0 | 1,1,0,1,1,0,0,0, then SE0, SE0, J; no get_tx_packet_data pulses; active for 19 cycles.
REQ-029 NAK and STALL at CLKS_PER_BIT=8 -> each line level held 8 cycles; PID bit stream matches 0x5A / 0x1E LSB first under NRZI.
REQ-030 DATA0, size 1, data 0xFF, CRC_EN=0 -> one stuffed 0 inserted after the 4th data bit (2 trailing PID ones + 4), then the remaining four 1s, then EOP; packet is 1 bit longer than unstuffed.
REQ-031 DATA1, size 2, bytes 0x00 and 0x01, CRC_EN=1 -> exactly two get_tx_packet_data pulses, then a CRC field equal to the complemented CRC16 of {0x00, 0x01} sent LSB first; size 0 -> CRC field 0x0000 (16 toggles).
REQ-032 DATA0 with size = MAX_BYTES+1, and code 7 -> one tx_error pulse each; lines stay J; tx_transfer_active stays 0.
REQ-033 rst asserted mid-DATA byte -> next edge shows J, active=0, no get pulses; a subsequent ACK transmits correctly from SYNC.
